pipelined_cla_adder: RTL



---
 rtl/pipelined_cla_adder.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipelined_cla_adder.sv
`default_nettype none
// ============================================================================
// Module : pipelined_cla_adder
// Desc   : Pipelined carry-lookahead add/sub, one register stage per GROUP-bit
//          group, valid/ready handshake. Optional macro: CLA_OVERFLOW_EN.
// Rev    : 1.0
// ============================================================================
module pipelined_cla_adder #(
  parameter int WIDTH = 32,
  parameter int GROUP = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int NGRP = WIDTH / GROUP;

  // Two-level lookahead: every carry is an OR of generate terms gated by the
  // propagate run above them, with no ripple dependency between carries.
  function automatic logic [GROUP:0] f_lookahead(input logic [GROUP-1:0] p,
                                                 input logic [GROUP-1:0] g,
                                                 input logic             ci);
    logic [GROUP:0] c;
    logic           term;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = ci;
      for (int m = 0; m <= i; m++) term = term & p[m];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
    return c;
  endfunction

  logic             w_adv;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_p0;
  logic [WIDTH-1:0] w_g0;
  logic             w_c0;

  assign w_adv    = !out_valid || out_ready;
  assign in_ready = w_adv;
  assign w_b_eff  = sub ? ~b : b;
  assign w_c0     = sub | cin;
  assign w_p0     = a ^ w_b_eff;
  assign w_g0     = a & w_b_eff;

  // r_x carries finished sum bits below the current group and propagate bits
  // from the current group upward; r_g holds generate bits of pending groups.
  for (genvar k = 0; k < NGRP; k++) begin : g_stage
    localparam int LO = k * GROUP;
    localparam int HI = LO + GROUP - 1;

    logic [WIDTH-1:0] w_xi;
    logic [WIDTH-1:0] w_xo;
    logic [WIDTH-1:LO] w_gi;
    logic             w_ci;
    logic             w_vi;
    logic [GROUP:0]   w_cg;
    logic [WIDTH-1:0] r_x;
    logic             r_c;
    logic             r_v;

    if (k == 0) begin : g_first
      assign w_xi = w_p0;
      assign w_gi = w_g0;
      assign w_ci = w_c0;
      assign w_vi = in_valid;
    end else begin : g_next
      assign w_xi = g_stage[k-1].r_x;
      assign w_gi = g_stage[k-1].g_pend.r_g;
      assign w_ci = g_stage[k-1].r_c;
      assign w_vi = g_stage[k-1].r_v;
    end

    assign w_cg = f_lookahead(w_xi[HI:LO], w_gi[HI:LO], w_ci);

    always_comb begin
      w_xo        = w_xi;
      w_xo[HI:LO] = w_xi[HI:LO] ^ w_cg[GROUP-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_x <= '0;
        r_c <= 1'b0;
        r_v <= 1'b0;
      end else if (w_adv) begin
        r_x <= w_xo;
        r_c <= w_cg[GROUP];
        r_v <= w_vi;
      end
    end

    if (k == NGRP - 1) begin : g_last
      assign sum       = r_x;
      assign carry     = r_c;
      assign out_valid = r_v;
`ifdef CLA_OVERFLOW_EN
      logic r_ovf;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_ovf <= 1'b0;
        else if (w_adv) r_ovf <= w_cg[GROUP] ^ w_cg[GROUP-1];
      end
      assign overflow = r_ovf;
`else
      assign overflow = 1'b0;
`endif
    end else begin : g_pend
      logic [WIDTH-1:LO+GROUP] r_g;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)     r_g <= '0;
        else if (w_adv) r_g <= w_gi[WIDTH-1:LO+GROUP];
      end
    end
  end

endmodule
`default_nettype wire
